// File: rtl/q2_pkg.sv
// Shared encodings and default word width for the Q2 datapath slice.
package q2_pkg;

  localparam int WIDTH_DEFAULT = 12;

  // X register source select
  typedef enum logic [1:0] {
    XSEL_ZERO  = 2'd0,
    XSEL_SHIFT = 2'd1,
    XSEL_P     = 2'd2,
    XSEL_DBUS  = 2'd3
  } xsel_t;

endpackage

// File: rtl/q2_datapath_if.sv
// Data/address bus bundle between the Q2 datapath and the top-level bus muxes.
import q2_pkg::*;

interface q2_datapath_if #(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic [WIDTH-1:0] sw;
  logic             dep;
  logic [WIDTH-1:0] dbus_in;
  logic [WIDTH-1:0] dbus_out;
  logic             dbus_oe;
  logic [WIDTH-1:0] abus_out;
  logic             abus_oe;

  modport master (
    output sw, dep, dbus_in,
    input  dbus_out, dbus_oe, abus_out, abus_oe
  );

  modport slave (
    input  sw, dep, dbus_in,
    output dbus_out, dbus_oe, abus_out, abus_oe
  );
endinterface

// File: rtl/q2_pc.sv
// Program counter: reset-to-switches, load from X, carry-propagating +1/+2.
import q2_pkg::*;

module q2_pc #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             incp_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             inc2,
  output logic [WIDTH-1:0] p
);

  logic [WIDTH-1:0] step;

  // Skip-by-two steps over the next word; otherwise a plain increment.
  always_comb begin
    step = inc2 ? WIDTH'(2) : WIDTH'(1);
  end

  // P register; the sum wraps naturally at 2^WIDTH. Load beats increment.
  always_ff @(posedge incp_clk or posedge rst) begin
    if (rst)       p <= sw;
    else if (load) p <= load_val;
    else if (inc)  p <= p + step;
  end

endmodule

// File: rtl/q2_datapath.sv
// Q2 word-wide register slice: A, X, P, S plus data/address bus drive and
// a sticky contention flag. Bus outputs are data+enable pairs, no tri-states.
import q2_pkg::*;

module q2_datapath #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             incp_clk,
  input  logic             rst,
  q2_datapath_if.slave     bus,
  input  logic             wra,
  input  logic             rda,
  input  logic [WIDTH-1:0] ain,
  input  logic             wrx,
  input  logic             rdx,
  input  logic [1:0]       xsel,
  input  logic             xshift,
  input  logic             incp,
  input  logic             skip,
  input  logic             wrp,
  input  logic             rdp,
  input  logic             wrs,
  input  logic             rsts,
  input  logic             sin,
  output logic [WIDTH-1:0] aout,
  output logic [WIDTH-1:0] xout,
  output logic [WIDTH-1:0] pout,
  output logic             sout,
  output logic             err
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] x_src;
  logic [WIDTH-1:0] p;
  logic             s;
  logic             skip_take;
  logic             contention;

  // A skip is only consumed when the increment actually happens (wrp wins).
  assign skip_take  = incp & ~wrp & skip & s;
  assign contention = (bus.dep & rda) | (rdx & rdp);

  q2_pc #(.WIDTH(WIDTH)) u_pc (
    .incp_clk (incp_clk),
    .rst      (rst),
    .sw       (bus.sw),
    .load     (wrp),
    .load_val (x),
    .inc      (incp),
    .inc2     (skip_take),
    .p        (p)
  );

  // Accumulator load from the ALU result.
  always_ff @(posedge incp_clk or posedge rst) begin
    if (rst)      a <= '0;
    else if (wra) a <= ain;
  end

  // X source mux; P and dbus_in are pre-edge values, giving swap and A->X in one clock.
  always_comb begin
    x_src = '0;
    case (xsel)
      XSEL_ZERO:  x_src = '0;
      XSEL_SHIFT: x_src = {x[WIDTH-2:0], xshift};
      XSEL_P:     x_src = p;
      XSEL_DBUS:  x_src = bus.dbus_in;
      default:    x_src = '0;
    endcase
  end

  // X register.
  always_ff @(posedge incp_clk or posedge rst) begin
    if (rst)      x <= '0;
    else if (wrx) x <= x_src;
  end

  // Skip flag: explicit clear beats skip consumption beats load.
  always_ff @(posedge incp_clk or posedge rst) begin
    if (rst)            s <= 1'b0;
    else if (rsts)      s <= 1'b0;
    else if (skip_take) s <= 1'b0;
    else if (wrs)       s <= sin;
  end

  // Sticky contention flag, cleared only by reset.
  always_ff @(posedge incp_clk or posedge rst) begin
    if (rst)             err <= 1'b0;
    else if (contention) err <= 1'b1;
  end

  // Bus drive: switches beat A on dbus, X beats P on abus; idle at zero.
  always_comb begin
    bus.dbus_out = '0;
    bus.abus_out = '0;
    if (bus.dep)  bus.dbus_out = bus.sw;
    else if (rda) bus.dbus_out = a;
    if (rdx)      bus.abus_out = x;
    else if (rdp) bus.abus_out = p;
  end

  assign bus.dbus_oe = bus.dep | rda;
  assign bus.abus_oe = rdx | rdp;

  assign aout = a;
  assign xout = x;
  assign pout = p;
  assign sout = s;

endmodule

// File: tb/tb_q2_datapath.sv
// Directed bench for q2_datapath: vector table plus reset/contention sequences.
module tb_q2_datapath;
  import q2_pkg::*;

  localparam int W = 12;

  localparam logic [12:0] WRA = 13'h0001, RDA = 13'h0002, WRX = 13'h0004,
                          RDX = 13'h0008, RDP = 13'h0010, WRP = 13'h0020,
                          INC = 13'h0040, SKP = 13'h0080, WRS = 13'h0100,
                          RSS = 13'h0200, SIN = 13'h0400, DEP = 13'h0800,
                          XSH = 13'h1000;

  typedef struct {
    string        name;
    logic [12:0]  st;
    logic [1:0]   xs;
    logic [W-1:0] sw;
    logic [W-1:0] ain;
    logic [W-1:0] e_dbus;
    logic         e_doe;
    logic [W-1:0] e_abus;
    logic         e_aoe;
    logic [W-1:0] e_a;
    logic [W-1:0] e_x;
    logic [W-1:0] e_p;
    logic         e_s;
    logic         e_err;
  } vec_t;

  logic incp_clk = 1'b0;
  logic rst = 1'b1;
  logic wra, rda, wrx, rdx, xshift, incp, skip, wrp, rdp, wrs, rsts, sin;
  logic [1:0]   xsel;
  logic [W-1:0] ain, aout, xout, pout;
  logic sout, err;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  q2_datapath_if #(.WIDTH(W)) bus ();

  // Resolved data bus: only this block drives it in the bench.
  assign bus.dbus_in = bus.dbus_oe ? bus.dbus_out : '0;

  q2_datapath #(.WIDTH(W)) dut (
    .incp_clk (incp_clk), .rst (rst), .bus (bus),
    .wra (wra), .rda (rda), .ain (ain),
    .wrx (wrx), .rdx (rdx), .xsel (xsel), .xshift (xshift),
    .incp (incp), .skip (skip), .wrp (wrp), .rdp (rdp),
    .wrs (wrs), .rsts (rsts), .sin (sin),
    .aout (aout), .xout (xout), .pout (pout), .sout (sout), .err (err)
  );

  always #5 incp_clk = ~incp_clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [12:0] st, input logic [1:0] xs,
                       input logic [W-1:0] swv, input logic [W-1:0] ainv);
    wra = st[0]; rda = st[1]; wrx = st[2]; rdx = st[3]; rdp = st[4];
    wrp = st[5]; incp = st[6]; skip = st[7]; wrs = st[8]; rsts = st[9];
    sin = st[10]; bus.dep = st[11]; xshift = st[12];
    xsel = xs; bus.sw = swv; ain = ainv;
  endtask

  task automatic chk_state(input string tag, input logic [W-1:0] ea, input logic [W-1:0] ex,
                           input logic [W-1:0] ep, input logic es, input logic ee);
    chk({tag, ".a"}, aout, ea);
    chk({tag, ".x"}, xout, ex);
    chk({tag, ".p"}, pout, ep);
    chk({tag, ".s"}, W'(sout), W'(es));
    chk({tag, ".err"}, W'(err), W'(ee));
  endtask

  function automatic vec_t v(string n, logic [12:0] st, logic [1:0] xs, logic [W-1:0] swv,
                             logic [W-1:0] ainv, logic [W-1:0] db, logic doe,
                             logic [W-1:0] ab, logic aoe, logic [W-1:0] ea,
                             logic [W-1:0] ex, logic [W-1:0] ep, logic es, logic ee);
    vec_t r;
    r.name = n; r.st = st; r.xs = xs; r.sw = swv; r.ain = ainv;
    r.e_dbus = db; r.e_doe = doe; r.e_abus = ab; r.e_aoe = aoe;
    r.e_a = ea; r.e_x = ex; r.e_p = ep; r.e_s = es; r.e_err = ee;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // state after each row: A X P S err
    vecs.push_back(v("wra",        WRA,           0, 12'h123, 12'hA5A, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'h000, 12'h123, 0, 0));
    vecs.push_back(v("a_to_x",     RDA|WRX,       3, 12'h123, 12'h000, 12'hA5A, 1, 12'h000, 0, 12'hA5A, 12'hA5A, 12'h123, 0, 0));
    vecs.push_back(v("x_shift",    WRX|XSH,       1, 12'h123, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'h4B5, 12'h123, 0, 0));
    vecs.push_back(v("rdx_wrp",    RDX|WRP,       0, 12'h123, 12'h000, 12'h000, 0, 12'h4B5, 1, 12'hA5A, 12'h4B5, 12'h4B5, 0, 0));
    vecs.push_back(v("x_zero",     WRX,           0, 12'h123, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'h000, 12'h4B5, 0, 0));
    vecs.push_back(v("inc1",       INC,           0, 12'h123, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'h000, 12'h4B6, 0, 0));
    vecs.push_back(v("wrs1",       WRS|SIN,       0, 12'h123, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'h000, 12'h4B6, 1, 0));
    vecs.push_back(v("skip_s1",    INC|SKP,       0, 12'h123, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'h000, 12'h4B8, 0, 0));
    vecs.push_back(v("skip_s0",    INC|SKP,       0, 12'h123, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'h000, 12'h4B9, 0, 0));
    vecs.push_back(v("rsts_wrs",   RSS|WRS|SIN,   0, 12'h123, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'h000, 12'h4B9, 0, 0));
    vecs.push_back(v("wrs_again",  WRS|SIN,       0, 12'h123, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'h000, 12'h4B9, 1, 0));
    vecs.push_back(v("wrp_vs_inc", WRP|INC,       0, 12'h123, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'h000, 12'h000, 1, 0));
    vecs.push_back(v("dep_fff",    DEP|WRX,       3, 12'hFFF, 12'h000, 12'hFFF, 1, 12'h000, 0, 12'hA5A, 12'hFFF, 12'h000, 1, 0));
    vecs.push_back(v("p_fff",      WRP,           0, 12'hFFF, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'hFFF, 12'hFFF, 1, 0));
    vecs.push_back(v("wrap_fff_1", INC,           0, 12'hFFF, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'hFFF, 12'h000, 1, 0));
    vecs.push_back(v("dep_ffe",    DEP|WRX,       3, 12'hFFE, 12'h000, 12'hFFE, 1, 12'h000, 0, 12'hA5A, 12'hFFE, 12'h000, 1, 0));
    vecs.push_back(v("p_ffe",      WRP,           0, 12'hFFE, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'hFFE, 12'hFFE, 1, 0));
    vecs.push_back(v("wrap_ffe_2", INC|SKP,       0, 12'hFFE, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'hFFE, 12'h000, 0, 0));
    vecs.push_back(v("dep_200",    DEP|WRX,       3, 12'h200, 12'h000, 12'h200, 1, 12'h000, 0, 12'hA5A, 12'h200, 12'h000, 0, 0));
    vecs.push_back(v("p_200",      WRP,           0, 12'h200, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'h200, 12'h200, 0, 0));
    vecs.push_back(v("dep_010",    DEP|WRX,       3, 12'h010, 12'h000, 12'h010, 1, 12'h000, 0, 12'hA5A, 12'h010, 12'h200, 0, 0));
    vecs.push_back(v("swap",       WRP|WRX,       2, 12'h010, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'h200, 12'h010, 0, 0));
    vecs.push_back(v("rdp",        RDP,           0, 12'h010, 12'h000, 12'h000, 0, 12'h010, 1, 12'hA5A, 12'h200, 12'h010, 0, 0));
    vecs.push_back(v("rdx_rdp",    RDX|RDP,       0, 12'h010, 12'h000, 12'h000, 0, 12'h200, 1, 12'hA5A, 12'h200, 12'h010, 0, 1));
    vecs.push_back(v("dep_rda",    DEP|RDA|WRX,   3, 12'h3C3, 12'h000, 12'h3C3, 1, 12'h000, 0, 12'hA5A, 12'h3C3, 12'h010, 0, 1));
    vecs.push_back(v("wrs_dep",    WRS|SIN|DEP|WRX, 3, 12'hFFF, 12'h000, 12'hFFF, 1, 12'h000, 0, 12'hA5A, 12'hFFF, 12'h010, 1, 1));
    vecs.push_back(v("p_fff_b",    WRP,           0, 12'hFFF, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'hFFF, 12'hFFF, 1, 1));
    vecs.push_back(v("wrap_fff_2", INC|SKP,       0, 12'hFFF, 12'h000, 12'h000, 0, 12'h000, 0, 12'hA5A, 12'hFFF, 12'h001, 0, 1));

    // Reset with sw=0x123, checked while held and after release.
    drive('0, 2'd0, 12'h123, 12'h000);
    rst = 1'b1;
    @(posedge incp_clk);
    @(negedge incp_clk);
    chk_state("rst_hold", 12'h000, 12'h000, 12'h123, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge incp_clk);
    #1;
    chk_state("rst_rel", 12'h000, 12'h000, 12'h123, 1'b0, 1'b0);
    @(negedge incp_clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].xs, vecs[i].sw, vecs[i].ain);
      #1;
      chk({vecs[i].name, ".dbus"}, bus.dbus_out, vecs[i].e_dbus);
      chk({vecs[i].name, ".dbus_oe"}, W'(bus.dbus_oe), W'(vecs[i].e_doe));
      chk({vecs[i].name, ".abus"}, bus.abus_out, vecs[i].e_abus);
      chk({vecs[i].name, ".abus_oe"}, W'(bus.abus_oe), W'(vecs[i].e_aoe));
      @(posedge incp_clk);
      #1;
      chk_state(vecs[i].name, vecs[i].e_a, vecs[i].e_x, vecs[i].e_p, vecs[i].e_s, vecs[i].e_err);
      @(negedge incp_clk);
    end

    // Mid-operation reset: immediate, and strobes ignored while held.
    drive(WRA|WRX|INC|WRS|SIN, 2'd3, 12'h123, 12'h777);
    rst = 1'b1;
    #1;
    chk_state("rst_async", 12'h000, 12'h000, 12'h123, 1'b0, 1'b0);
    @(posedge incp_clk);
    #1;
    chk_state("rst_strobes", 12'h000, 12'h000, 12'h123, 1'b0, 1'b0);
    @(negedge incp_clk);
    drive('0, 2'd0, 12'h456, 12'h000);
    rst = 1'b0;

    // Fresh dbus contention: sw wins, err sets and sticks until reset.
    @(negedge incp_clk);
    drive(DEP|RDA, 2'd0, 12'h456, 12'h000);
    #1;
    chk("cont.dbus", bus.dbus_out, 12'h456);
    chk("cont.err_pre", W'(err), W'(1'b0));
    @(posedge incp_clk);
    #1;
    chk("cont.err_set", W'(err), W'(1'b1));
    @(negedge incp_clk);
    drive('0, 2'd0, 12'h456, 12'h000);
    repeat (2) @(posedge incp_clk);
    #1;
    chk("cont.err_sticky", W'(err), W'(1'b1));
    chk("idle.dbus", bus.dbus_out, 12'h000);
    chk("idle.abus", bus.abus_out, 12'h000);
    @(negedge incp_clk);
    rst = 1'b1;
    #1;
    chk("cont.err_clr", W'(err), W'(1'b0));
    chk("rst_sw456.p", pout, 12'h456);
    @(negedge incp_clk);
    rst = 1'b0;
    @(negedge incp_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/q2_datapath.md
# q2_datapath

Word-wide, single-clock successor to the Q2 per-bit register slice. It holds the accumulator A, index/transfer register X, program counter P and skip flag S for a WIDTH-bit word. P uses a true carry-propagating increment with optional skip-by-two. Bus drive is returned as data plus output-enable pairs for the top-level bus muxes, so the block contains no internal tri-states.

## Interface
- WIDTH, 12, word width in bits (≥2)
- rst  in  1  asynchronous, active-high reset
- incp_clk  in  1  clock; all registers update on its rising edge
- sw  in  WIDTH  front-panel switches; reset value of P, deposit data
- dep  in  1  deposit: place sw on data bus
- dbus_in  in  WIDTH  resolved data bus value
- dbus_out / dbus_oe  out  WIDTH / 1  data bus drive and enable
- abus_out / abus_oe  out  WIDTH / 1  address bus drive and enable
- wra, rda  in  1  load A from ain / drive A onto dbus
- ain  in  WIDTH  A load data (ALU result)
- wrx, rdx  in  1  load X / drive X onto abus
- xsel  in  2  X source: 0 zero, 1 shift, 2 P, 3 dbus_in
- xshift  in  1  serial bit shifted into X[0]
- incp, skip  in  1  advance P; honour S for skip-by-two
- wrp, rdp  in  1  load P from X / drive P onto abus
- wrs, rsts, sin  in  1  load S from sin / clear S
- aout, xout, pout  out  WIDTH  register contents
- sout  out  1  S contents
- err  out  1  sticky bus-contention flag

## Operation
- Reset (async assert, sync-safe release): A=0, X=0, P=sw (sampled while rst high), S=0, err=0.
- A: on wra, A←ain.
- X: on wrx, X←{0 | {X[WIDTH-2:0],xshift} | P | dbus_in} per xsel.
- P priority: wrp > incp. wrp: P←X. incp: P←P+2 if skip and S, else P+1; modulo 2^WIDTH (0xFFF+1→0x000, 0xFFE+2→0x000, 0xFFF+2→0x001). Skip consumed: S←0 in the same edge.
- S priority: rsts > skip-consume > wrs. rsts: S←0. wrs: S←sin.
- wrx with xsel=2 and wrp on the same edge: X←old P, P←old X (swap).
- dbus: dep drives sw, else rda drives A; dbus_oe=dep|rda. Both asserted → sw wins, err set.
- abus: rdx drives X, else rdp drives P; abus_oe=rdx|rdp. Both asserted → X wins, err set.
- err clears only on rst.
- Bus outputs idle at 0 when oe=0.

## Timing
- Register updates: one edge latency; aout/xout/pout/sout are register outputs.
- dbus_out/abus_out/oe: combinational from current registers and strobes, same cycle.
- X load from dbus_in uses the value present before the edge, so rda+wrx(xsel=3) in one cycle transfers A→X in one clock.
- Mid-operation rst: all state forced to reset values immediately; pending strobes are ignored until rst deasserts.

## Structure
- Shared package q2_pkg holds the XSEL_ZERO/SHIFT/P/DBUS encodings and the default word width.
- One sub-module: q2_pc (P register: load, +1/+2 increment, reset-to-sw), instantiated once; A, X, S, bus muxes and err inline.

## Test plan
- rst with sw=0x123 → pout=0x123, aout=xout=0, sout=0, err=0 while rst high and after release.
- P=0xFFF, incp → 0x000; S=1, skip, P=0xFFE, incp → P=0x000, S=0; S=0, skip, incp → +1 only.
- ain=0xA5A, wra then rda+wrx(xsel=3) → xout=0xA5A after one edge; wrx xsel=1 xshift=1 → 0x4B5.
- X=0x010, P=0x200, wrp+wrx(xsel=2) same edge → P=0x010, X=0x200.
- dep+rda → dbus_out=sw, err=1 and stays 1 until rst; rdx+rdp → abus_out=X.
- rsts+wrs sin=1 same edge → S=0; wrs alone sin=1 → S=1.
